// File: rtl/bus_pkg.sv
// Shared types and encodings for the 8085 bus cycle controller.
// Status and T-state codes match the pin-level and decoder conventions.
package bus_pkg;

    typedef enum logic [2:0] {
        CYC_FETCH = 3'd0,
        CYC_MRD   = 3'd1,
        CYC_MWR   = 3'd2,
        CYC_IORD  = 3'd3,
        CYC_IOWR  = 3'd4,
        CYC_INTA  = 3'd5
    } cyc_type_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_TW,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HOLD
    } bus_state_e;

    localparam logic [2:0] STAT_FETCH = 3'b011;
    localparam logic [2:0] STAT_MRD   = 3'b010;
    localparam logic [2:0] STAT_MWR   = 3'b001;
    localparam logic [2:0] STAT_IORD  = 3'b110;
    localparam logic [2:0] STAT_IOWR  = 3'b101;
    localparam logic [2:0] STAT_INTA  = 3'b111;

    localparam logic [6:0] TS_T1     = 7'b1000000;
    localparam logic [6:0] TS_T2     = 7'b0100000;
    localparam logic [6:0] TS_T3     = 7'b0010000;
    localparam logic [6:0] TS_T4     = 7'b0001000;
    localparam logic [6:0] TS_T5     = 7'b0000100;
    localparam logic [6:0] TS_T6     = 7'b0000010;
    localparam logic [6:0] TS_TRESET = 7'b0000001;

    function automatic logic [2:0] cyc_status(cyc_type_e t);
        logic [2:0] s;
        case (t)
            CYC_FETCH: s = STAT_FETCH;
            CYC_MRD:   s = STAT_MRD;
            CYC_MWR:   s = STAT_MWR;
            CYC_IORD:  s = STAT_IORD;
            CYC_IOWR:  s = STAT_IOWR;
            CYC_INTA:  s = STAT_INTA;
            default:   s = STAT_FETCH;
        endcase
        return s;
    endfunction

    function automatic logic is_read(cyc_type_e t);
        return (t == CYC_FETCH) || (t == CYC_MRD) ||
               (t == CYC_IORD) || (t == CYC_INTA);
    endfunction

    function automatic logic is_fetch_like(cyc_type_e t);
        return (t == CYC_FETCH) || (t == CYC_INTA);
    endfunction

    function automatic logic [6:0] tstate_code(bus_state_e s);
        logic [6:0] c;
        case (s)
            ST_T1:   c = TS_T1;
            ST_T2:   c = TS_T2;
            ST_T3:   c = TS_T3;
            ST_T4:   c = TS_T4;
            ST_T5:   c = TS_T5;
            ST_T6:   c = TS_T6;
            default: c = TS_TRESET;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Counts consecutive wait states and flags when the wait limit is reached.
// A limit of zero disables the forced termination.
module bus_wait_timer
    import bus_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int WCNT_W   = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_max_o
);

    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    always_comb begin
        wcnt_d = wcnt_q;
        if (clr_i) begin
            wcnt_d = '0;
        end else if (inc_i) begin
            wcnt_d = wcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    assign at_max_o = (MAX_WAIT != 0) &&
                      (wcnt_q == WCNT_W'(MAX_WAIT));

endmodule

// File: rtl/bus_cycle_ctrl.sv
// 8085 external bus machine-cycle sequencer: strobes, status, AD mux,
// READY wait states and HOLD/HLDA arbitration.
module bus_cycle_ctrl
    import bus_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int WCNT_W   = 4
) (
    input  logic        phi1,
    input  logic        resetn,
    input  logic        cyc_req,
    input  logic [2:0]  cyc_type,
    input  logic        cyc_long,
    input  logic [15:0] cyc_addr,
    input  logic [7:0]  cyc_wdata,
    output logic        cyc_ack,
    output logic        cyc_done,
    output logic        cyc_err,
    output logic [7:0]  rdata,
    output logic [6:0]  tstate,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    input  logic [7:0]  ad_in,
    output logic [7:0]  a_hi,
    output logic        addr_oe,
    output logic        ALE,
    output logic        RDn,
    output logic        WRn,
    output logic        IOMn,
    output logic        S1,
    output logic        S0,
    output logic        ctl_oe,
    input  logic        READY,
    input  logic        HOLD,
    output logic        HLDA
);

    bus_state_e state_q, state_d;

    cyc_type_e   type_q, type_n;
    logic        long_q, long_n;
    logic [15:0] addr_q, addr_n;
    logic [7:0]  wdata_q, wdata_n;

    logic boundary, req_ok, ack, bad;
    logic tmo_hit, wait_inc, at_max, tmo_q;

    logic       ale_q, rdn_q, wrn_q;
    logic [2:0] stat_q;
    logic [7:0] ad_out_q, a_hi_q, rdata_q;
    logic       ad_oe_q, addr_oe_q, ctl_oe_q;
    logic       hlda_q, done_q, err_q;
    logic [6:0] tstate_q;

    assign req_ok = (cyc_type <= 3'd5);

    always_comb begin
        boundary = 1'b0;
        unique case (state_q)
            ST_IDLE: boundary = 1'b1;
            ST_T3:   boundary = !is_fetch_like(type_q);
            ST_T4:   boundary = !long_q;
            ST_T6:   boundary = 1'b1;
            default: boundary = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ack      = 1'b0;
        bad      = 1'b0;
        tmo_hit  = 1'b0;
        wait_inc = 1'b0;
        if (boundary) begin
            if (HOLD) begin
                state_d = ST_HOLD;
            end else if (cyc_req && req_ok) begin
                ack     = 1'b1;
                state_d = ST_T1;
            end else begin
                bad     = cyc_req;
                state_d = ST_IDLE;
            end
        end else begin
            unique case (state_q)
                ST_T1: state_d = ST_T2;
                ST_T2, ST_TW: begin
                    if (state_q == ST_TW && at_max) begin
                        state_d = ST_T3;
                        tmo_hit = 1'b1;
                    end else if (READY) begin
                        state_d = ST_T3;
                    end else begin
                        state_d  = ST_TW;
                        wait_inc = 1'b1;
                    end
                end
                ST_T3:   state_d = ST_T4;
                ST_T4:   state_d = ST_T5;
                ST_T5:   state_d = ST_T6;
                ST_HOLD: state_d = HOLD ? ST_HOLD : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs for the entered state are built from the freshly latched request.
    assign type_n  = ack ? cyc_type_e'(cyc_type) : type_q;
    assign long_n  = ack ? cyc_long  : long_q;
    assign addr_n  = ack ? cyc_addr  : addr_q;
    assign wdata_n = ack ? cyc_wdata : wdata_q;

    bus_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WCNT_W   (WCNT_W)
    ) u_wait (
        .clk_i    (phi1),
        .rst_ni   (resetn),
        .clr_i    (state_d == ST_T1),
        .inc_i    (wait_inc),
        .at_max_o (at_max)
    );

    always_ff @(posedge phi1 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            type_q    <= CYC_FETCH;
            long_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tmo_q     <= 1'b0;
            ale_q     <= 1'b0;
            rdn_q     <= 1'b1;
            wrn_q     <= 1'b1;
            stat_q    <= 3'b000;
            ad_out_q  <= '0;
            ad_oe_q   <= 1'b0;
            a_hi_q    <= '0;
            addr_oe_q <= 1'b0;
            ctl_oe_q  <= 1'b0;
            hlda_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            tstate_q  <= TS_TRESET;
        end else begin
            state_q  <= state_d;
            type_q   <= type_n;
            long_q   <= long_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
            tstate_q <= tstate_code(state_d);
            hlda_q   <= (state_d == ST_HOLD);
            ctl_oe_q <= (state_d != ST_HOLD);
            done_q   <= (state_q == ST_T3);
            err_q    <= bad || (state_q == ST_T3 && tmo_q);
            if (state_q == ST_T3 && is_read(type_q)) begin
                rdata_q <= ad_in;
            end
            if (state_d == ST_T1) begin
                tmo_q <= 1'b0;
            end else if (tmo_hit) begin
                tmo_q <= 1'b1;
            end
            ale_q     <= (state_d == ST_T1);
            rdn_q     <= 1'b1;
            wrn_q     <= 1'b1;
            ad_oe_q   <= 1'b0;
            addr_oe_q <= 1'b0;
            unique case (state_d)
                ST_T1: begin
                    ad_out_q  <= addr_n[7:0];
                    ad_oe_q   <= 1'b1;
                    a_hi_q    <= addr_n[15:8];
                    addr_oe_q <= 1'b1;
                    stat_q    <= cyc_status(type_n);
                end
                ST_T2, ST_TW, ST_T3: begin
                    addr_oe_q <= 1'b1;
                    if (is_read(type_n)) begin
                        rdn_q <= 1'b0;
                    end else begin
                        wrn_q    <= 1'b0;
                        ad_out_q <= wdata_n;
                        ad_oe_q  <= 1'b1;
                    end
                end
                ST_T4, ST_T5, ST_T6: addr_oe_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign cyc_ack  = ack;
    assign cyc_done = done_q;
    assign cyc_err  = err_q;
    assign rdata    = rdata_q;
    assign tstate   = tstate_q;
    assign ad_out   = ad_out_q;
    assign ad_oe    = ad_oe_q;
    assign a_hi     = a_hi_q;
    assign addr_oe  = addr_oe_q;
    assign ALE      = ale_q;
    assign RDn      = rdn_q;
    assign WRn      = wrn_q;
    assign IOMn     = stat_q[2];
    assign S1       = stat_q[1];
    assign S0       = stat_q[0];
    assign ctl_oe   = ctl_oe_q;
    assign HLDA     = hlda_q;

endmodule

// File: doc/bus_cycle_ctrl.md
Name: bus_cycle_ctrl

Overview:
- Sequences 8085 external bus machine cycles: opcode fetch, memory read/write, I/O read/write and interrupt acknowledge.
- Generates ALE, RDn, WRn, IOMn, S1 and S0, drives the multiplexed AD bus, inserts READY wait states and arbitrates HOLD/HLDA.
- Sits between the instruction sequencer (request side) and the pins. Exports the current T-state one-hot, using the decoder's T-state encoding.

Parameters:
- MAX_WAIT, 15, maximum consecutive TW states before forced termination; 0 = unlimited.
- WCNT_W, 4, wait-counter width; must satisfy 2**WCNT_W > MAX_WAIT.

Ports:
- phi1 in 1: single system clock, one T-state per cycle.
- resetn in 1: asynchronous, active-low reset.
- cyc_req in 1: requester holds high until cyc_ack.
- cyc_type in 3: 0 FETCH, 1 MRD, 2 MWR, 3 IORD, 4 IOWR, 5 INTA; 6 and 7 invalid.
- cyc_long in 1: FETCH/INTA uses 6 T-states instead of 4.
- cyc_addr in 16: cycle address.
- cyc_wdata in 8: write data.
- cyc_ack out 1: combinational; request latched on this edge.
- cyc_done out 1: one-cycle pulse, cycle complete.
- cyc_err out 1: one-cycle pulse, invalid type or wait timeout.
- rdata out 8: data captured at end of T3.
- tstate out 7: one-hot T1=1000000 … T6=0000010; 0000001 = idle/TW/hold.
- ad_out out 8, ad_oe out 1, ad_in in 8: multiplexed AD[7:0].
- a_hi out 8: A[15:8].
- addr_oe out 1: enables a_hi.
- ALE, RDn, WRn, IOMn, S1, S0 out 1 each.
- ctl_oe out 1: enables RDn/WRn/IOMn/S1/S0.
- READY in 1, HOLD in 1, HLDA out 1.

Behaviour:
- Reset (async, while resetn=0) forces these values:
  - state IDLE, ALE=0, RDn=1, WRn=1, IOMn=0, S1=S0=0.
  - ad_oe=addr_oe=ctl_oe=0, HLDA=0, cyc_done=cyc_err=0, rdata=0, wcnt=0, tstate=0000001.
- First cycle after release: IDLE with ctl_oe=1.
- States: IDLE, T1, T2, TW, T3, T4, T5, T6, HOLD.
- Boundary points: IDLE; T3 of MRD/MWR/IORD/IOWR; T4 of short FETCH/INTA; T6 of long FETCH/INTA.
- Priority at a boundary, HOLD sampled high: next state HOLD, cyc_ack=0.
- Otherwise, cyc_req=1 with valid type:
  - cyc_ack=1; type, long, addr and wdata are latched; next state T1.
  - Back-to-back cycles run with no idle state between them.
- Invalid type at a boundary: not acked; cyc_err pulses next cycle; the requester must drop or change the request.
- Nothing pending at a boundary: next state IDLE.
- Status {IOMn,S1,S0} is set from T1 through the end of the cycle:
  - FETCH 011, MRD 010, MWR 001, IORD 110, IOWR 101, INTA 111.
  - In IDLE the last value is held.
- T1:
  - ALE=1, ad_out=addr[7:0], ad_oe=1.
  - a_hi=addr[15:8], addr_oe=1; a_hi holds through the last T-state of the cycle.
- T2, reads (FETCH/MRD/IORD/INTA): RDn=0, ad_oe=0.
- T2, writes: WRn=0, ad_out=wdata, ad_oe=1.
- READY is sampled on the T2→ edge and on each TW→ edge:
  - READY=0 → TW, strobes and write data held.
  - READY=1 → T3.
- Wait timeout: wcnt increments per TW. With MAX_WAIT≠0 and wcnt==MAX_WAIT, go to T3 regardless of READY and flag cyc_err with that cycle's cyc_done. wcnt clears in T1.
- T3:
  - Strobe still active; rdata<=ad_in on the T3→ edge for reads.
  - RDn/WRn return to 1 in the following cycle; ad_oe drops after T3.
- cyc_done pulses in the cycle immediately after T3 for every type; for FETCH/INTA this is T4.
- T4–T6 (FETCH/INTA): RDn=WRn=1, ad_oe=0, status held; T5/T6 only if cyc_long.
- HOLD entry:
  - HLDA=1 from the first HOLD cycle.
  - ad_oe=addr_oe=ctl_oe=0; ALE=0.
- HOLD exit: HOLD sampled 0 → HLDA=0 next cycle, state IDLE for one cycle with outputs re-enabled, then normal boundary rules.
- HOLD raised mid-cycle: the current cycle completes; the hold is granted only at the next boundary.
- Reset mid-cycle: immediate abort, no cyc_done, reset values above.

Decomposition:
- Shared package bus_pkg holds:
  - the cyc_type enum;
  - the state enum;
  - 3-bit status constants;
  - T-state one-hot constants, identical to the decoder's T1..T6/Treset codes.
- No sub-module required. Optional sub-module bus_wait_timer holds the wcnt and timeout compare.

Test Plan:
- Reset with resetn=0 mid-TW → all outputs at reset values the same cycle; after release, IDLE with ctl_oe=1 and no cyc_done.
- MRD addr=0x1234, READY=1, ad_in=0x5A:
  - T1 ALE=1, ad_out=0x34, a_hi=0x12, status 010.
  - RDn=0 in T2–T3; cyc_done with rdata=0x5A the next cycle; 3 bus T-states total.
- IOWR addr=0x0080, wdata=0xC3, READY low for 2 samples:
  - T1,T2,TW,TW,T3; WRn=0 for 4 cycles; ad_out=0xC3 through T3; status 101.
- FETCH cyc_long=1 then MRD queued:
  - T1..T6 with tstate codes; status 011; RDn high T4–T6; cyc_done in T4.
  - MRD acked at T6; next T1 follows directly.
- MWR with HOLD raised in T2:
  - cycle completes T3; HOLD state; HLDA=1; all oe=0.
  - HOLD drops → HLDA=0 next cycle, one IDLE, pending request acked, then T1.
- MAX_WAIT=3 with READY stuck low → exactly 3 TW, then T3; cyc_done and cyc_err pulse together.
- cyc_type=6 → no ack; cyc_err one-cycle pulse; bus stays IDLE.
